// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA binary-to-BCD converter.
package vga_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    localparam logic [3:0]  OVF_CODE  = 4'hE;
    localparam logic [3:0]  NEG_CODE  = 4'hF;
    localparam int unsigned NUM_ITER  = 32;
    localparam logic [5:0]  ITER_LAST = 6'(NUM_ITER - 1);

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 on every nibble >= 5, then shift in the operand MSB.
module bcd_dabble_step (
    input  logic [39:0] scratch_i,
    input  logic        msb_i,
    output logic [39:0] scratch_o
);

    logic [39:0] adj;

    always_comb begin
        adj = scratch_i;
        for (int i = 0; i < 10; i++) begin
            if (scratch_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_i[4*i +: 4] + 4'd3;
            end
        end
    end

    assign scratch_o = {adj[38:0], msb_i};

endmodule

// File: rtl/vga_bcd_conv.sv
// Sequential 32-bit binary to 8-digit BCD converter feeding the VGA display digits.
// Define VGA_BCD_SIGNED_EN to treat wr_data as two's complement with a leading '-' nibble.
module vga_bcd_conv
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic [31:0] digit,
    output logic        upd,
    output logic        ovf
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [39:0] scratch_q, scratch_d;
    logic        neg_q, neg_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] digit_q, digit_d;
    logic        ovf_q, ovf_d;
    logic        upd_q, upd_d;

    logic [39:0] step_out;
    logic        load_en;
    logic [31:0] load_val;

    bcd_dabble_step u_step (
        .scratch_i (scratch_q),
        .msb_i     (opnd_q[31]),
        .scratch_o (step_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        scratch_d   = scratch_q;
        neg_d       = neg_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        digit_d     = digit_q;
        ovf_d       = ovf_q;
        upd_d       = 1'b0;
        load_en     = 1'b0;
        load_val    = wr_data;

        case (state_q)
            StIdle: begin
                load_en = wr_en;
            end
            StConv: begin
                if (wr_en) begin
                    pend_d      = 1'b1;
                    pend_data_d = wr_data;
                end
                scratch_d = step_out;
                opnd_d    = {opnd_q[30:0], 1'b0};
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == ITER_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                upd_d = 1'b1;
                if (neg_q) begin
                    if (|scratch_q[39:28]) begin
                        digit_d = {8{OVF_CODE}};
                        ovf_d   = 1'b1;
                    end else begin
                        digit_d = {NEG_CODE, scratch_q[27:0]};
                        ovf_d   = 1'b0;
                    end
                end else if (|scratch_q[39:32]) begin
                    digit_d = {8{OVF_CODE}};
                    ovf_d   = 1'b1;
                end else begin
                    digit_d = scratch_q[31:0];
                    ovf_d   = 1'b0;
                end
                // A write landing in this cycle is newer than anything already pending.
                if (wr_en) begin
                    load_en  = 1'b1;
                    load_val = wr_data;
                end else if (pend_q) begin
                    load_en  = 1'b1;
                    load_val = pend_data_q;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_en) begin
            state_d   = StConv;
            cnt_d     = 6'd0;
            scratch_d = '0;
            pend_d    = 1'b0;
`ifdef VGA_BCD_SIGNED_EN
            neg_d  = load_val[31];
            opnd_d = abs32(load_val);
`else
            neg_d  = 1'b0;
            opnd_d = load_val;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opnd_q      <= '0;
            scratch_q   <= '0;
            neg_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            digit_q     <= '0;
            ovf_q       <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            scratch_q   <= scratch_d;
            neg_q       <= neg_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            digit_q     <= digit_d;
            ovf_q       <= ovf_d;
            upd_q       <= upd_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign digit = digit_q;
    assign upd   = upd_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_vga_bcd_conv.sv
// Directed self-checking bench for vga_bcd_conv; expectations follow VGA_BCD_SIGNED_EN if defined.
module tb_vga_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        busy;
    logic [31:0] digit;
    logic        upd;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    vga_bcd_conv dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .busy    (busy),
        .digit   (digit),
        .upd     (upd),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns on the negedge right after the sampling edge E0.
    task automatic do_write(input logic [31:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_upd(input string tag, output int cyc, output int busy_hi);
        cyc     = 0;
        busy_hi = 0;
        while (!upd && cyc < 100) begin
            if (busy) busy_hi++;
            @(negedge clk);
            cyc++;
        end
        if (!upd) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no upd, expected upd within 100 cycles", tag);
        end
    endtask

    task automatic run_conv(input string tag, input logic [31:0] v,
                            input logic [31:0] exp_d, input logic exp_o);
        int cyc;
        int bh;
        do_write(v);
        wait_upd(tag, cyc, bh);
        check_eq({tag, "_lat"}, 32'(cyc), 32'd33);
        check_eq({tag, "_busy_cycles"}, 32'(bh), 32'd33);
        check_eq({tag, "_digit"}, digit, exp_d);
        check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
        @(negedge clk);
        check_eq({tag, "_upd_one"}, {31'd0, upd}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Writes v0, then va at negedge ka and vb at negedge kb (0 = unused); logs two commits.
    task automatic run_chain(input string tag, input logic [31:0] v0,
                             input int ka, input logic [31:0] va,
                             input int kb, input logic [31:0] vb,
                             input logic [31:0] exp1, input logic [31:0] exp2);
        int n_upd = 0;
        int k1 = 0;
        int k2 = 0;
        int drops = 0;
        logic [31:0] d1 = '0;
        logic [31:0] d2 = '0;
        do_write(v0);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (k == ka) begin wr_en = 1'b1; wr_data = va; end
            if (k == kb) begin wr_en = 1'b1; wr_data = vb; end
            if (upd) begin
                n_upd++;
                if (n_upd == 1) begin k1 = k; d1 = digit; end
                if (n_upd == 2) begin k2 = k; d2 = digit; end
            end
            if (k < 66 && !busy) drops++;
        end
        wr_en = 1'b0;
        check_eq({tag, "_n_upd"}, 32'(n_upd), 32'd2);
        check_eq({tag, "_t1"}, 32'(k1), 32'd33);
        check_eq({tag, "_d1"}, d1, exp1);
        check_eq({tag, "_t2"}, 32'(k2), 32'd66);
        check_eq({tag, "_d2"}, d2, exp2);
        check_eq({tag, "_busy_drops"}, 32'(drops), 32'd0);
        check_eq({tag, "_idle_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_digit", digit, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("rst_upd", {31'd0, upd}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_conv("c12345678", 32'd12345678, 32'h12345678, 1'b0);
        run_conv("c0", 32'd0, 32'h00000000, 1'b0);
        run_conv("cmax", 32'd99_999_999, 32'h99999999, 1'b0);
        run_conv("covf", 32'd100_000_000, 32'hEEEEEEEE, 1'b1);
`ifdef VGA_BCD_SIGNED_EN
        run_conv("cneg10", 32'hFFFFFFF6, 32'hF0000010, 1'b0);
        run_conv("cmin", 32'h80000000, 32'hEEEEEEEE, 1'b1);
`else
        run_conv("cbig", 32'hFFFFFFF6, 32'hEEEEEEEE, 1'b1);
`endif

        run_chain("chain", 32'd5, 10, 32'd7, 20, 32'd9, 32'h00000005, 32'h00000009);
        run_chain("donewr", 32'h11, 32, 32'h22, 0, 32'd0, 32'h00000017, 32'h00000034);

        run_conv("pre_rst", 32'h42, 32'h00000066, 1'b0);
        do_write(32'd1234);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_digit", digit, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_upd", {31'd0, upd}, 32'd0);
        check_eq("midrst_ovf", {31'd0, ovf}, 32'd0);
        run_conv("post_rst", 32'd3, 32'h00000003, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
